// File: rtl/ga_pkg.sv
// Types and constants shared by the GA parent-gene fetcher and the child-gene collector.
package ga_pkg;

   localparam int GENE_W_DEFAULT = 32;
   localparam int SKID_DEPTH     = 2;
   localparam int OCC_W          = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_FETCH,
      S_DRAIN,
      S_DONE
   } fetch_state_e;

   function automatic logic hs_fire(input logic valid, input logic ready);
      return valid & ready;
   endfunction

endpackage

// File: rtl/gene_pair_skid.sv
// Two-entry pair buffer; the head entry is a plain register so the stream outputs are glitch-free.
module gene_pair_skid
   import ga_pkg::*;
#(
   parameter int W = 65
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [W-1:0]     push_data_i,
   input  logic             pop_i,
   output logic [W-1:0]     head_data_o,
   output logic             head_valid_o,
   output logic [OCC_W-1:0] occ_o
);

   logic [W-1:0]     head_q;
   logic [W-1:0]     tail_q;
   logic [OCC_W-1:0] occ_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         unique case (occ_q)
            2'd0: begin
               if (push_i) begin
                  head_q <= push_data_i;
                  occ_q  <= 2'd1;
               end
            end
            2'd1: begin
               if (push_i && pop_i) begin
                  head_q <= push_data_i;
               end else if (push_i) begin
                  tail_q <= push_data_i;
                  occ_q  <= 2'd2;
               end else if (pop_i) begin
                  occ_q  <= 2'd0;
               end
            end
            // Full: the producer never pushes here without a simultaneous pop.
            2'd2: begin
               if (pop_i) begin
                  head_q <= tail_q;
                  if (push_i) begin
                     tail_q <= push_data_i;
                  end else begin
                     occ_q <= 2'd1;
                  end
               end
            end
            default: occ_q <= '0;
         endcase
      end
   end

   assign head_data_o  = head_q;
   assign head_valid_o = (occ_q != '0);
   assign occ_o        = occ_q;

endmodule

// File: rtl/gene_pair_fetch.sv
// Fetches two parent genomes word by word over dual read ports and streams aligned gene pairs.
module gene_pair_fetch
   import ga_pkg::*;
#(
   parameter int GENE_W = GENE_W_DEFAULT,
   parameter int ADDR_W = 12,
   parameter int IDX_W  = 8,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IDX_W-1:0]  parent_idx0,
   input  logic [IDX_W-1:0]  parent_idx1,
   input  logic [LEN_W-1:0]  genome_len,
   output logic              mem_rd_en0,
   output logic [ADDR_W-1:0] mem_addr0,
   input  logic [GENE_W-1:0] mem_rdata0,
   output logic              mem_rd_en1,
   output logic [ADDR_W-1:0] mem_addr1,
   input  logic [GENE_W-1:0] mem_rdata1,
   output logic [GENE_W-1:0] parent_gene0,
   output logic [GENE_W-1:0] parent_gene1,
   output logic              gene_valid,
   input  logic              gene_ready,
   output logic              gene_last,
   output logic              busy,
   output logic              done
);

   localparam int PAIR_W = 2 * GENE_W + 1;
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   fetch_state_e      state_q;
   logic [IDX_W-1:0]  idx0_q;
   logic [IDX_W-1:0]  idx1_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  word_q;
   logic [ADDR_W-1:0] base0_q;
   logic [ADDR_W-1:0] base1_q;
   logic              inflight_q;
   logic              inflight_last_q;
   logic              busy_q;
   logic              done_q;

   logic [OCC_W-1:0]  occ;
   logic [PAIR_W-1:0] head;
   logic              head_valid;
   logic              pop;
   logic [2:0]        credit;
   logic              issue;
   logic              issue_last;

   assign pop        = hs_fire(head_valid, gene_ready);
   // A pair leaving this cycle frees its slot, which keeps one read per cycle in steady state.
   assign credit     = 3'(occ) + 3'(inflight_q) - 3'(pop);
   assign issue      = (state_q == S_FETCH) && (credit < 3'd2);
   assign issue_last = (word_q == len_q - LEN_ONE);

   assign mem_rd_en0 = issue;
   assign mem_rd_en1 = issue;
   assign mem_addr0  = base0_q + ADDR_W'(word_q);
   assign mem_addr1  = base1_q + ADDR_W'(word_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q         <= S_IDLE;
         idx0_q          <= '0;
         idx1_q          <= '0;
         len_q           <= '0;
         word_q          <= '0;
         base0_q         <= '0;
         base1_q         <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         inflight_q      <= issue;
         inflight_last_q <= issue && issue_last;
         done_q          <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  idx0_q  <= parent_idx0;
                  idx1_q  <= parent_idx1;
                  len_q   <= genome_len;
                  busy_q  <= 1'b1;
                  state_q <= S_SETUP;
               end
            end
            S_SETUP: begin
               base0_q <= ADDR_W'(idx0_q) * ADDR_W'(len_q);
               base1_q <= ADDR_W'(idx1_q) * ADDR_W'(len_q);
               word_q  <= '0;
               if (len_q == '0) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  state_q <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (issue) begin
                  word_q <= word_q + LEN_ONE;
                  if (issue_last) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (!inflight_q && (occ == '0 || (occ == OCC_W'(1) && pop))) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   gene_pair_skid #(
      .W (PAIR_W)
   ) u_skid (
      .clk          (clk),
      .rst          (rst),
      .push_i       (inflight_q),
      .push_data_i  ({mem_rdata0, mem_rdata1, inflight_last_q}),
      .pop_i        (pop),
      .head_data_o  (head),
      .head_valid_o (head_valid),
      .occ_o        (occ)
   );

   assign parent_gene0 = head[PAIR_W-1 -: GENE_W];
   assign parent_gene1 = head[GENE_W -: GENE_W];
   assign gene_last    = head[0];
   assign gene_valid   = head_valid;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_gene_pair_fetch.sv
// Self-checking bench: command table plus hand sequences, scoreboard of expected addresses and pairs.
module tb_gene_pair_fetch;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  parent_idx0;
   logic [7:0]  parent_idx1;
   logic [7:0]  genome_len;
   logic        mem_rd_en0;
   logic [11:0] mem_addr0;
   logic [31:0] mem_rdata0;
   logic        mem_rd_en1;
   logic [11:0] mem_addr1;
   logic [31:0] mem_rdata1;
   logic [31:0] parent_gene0;
   logic [31:0] parent_gene1;
   logic        gene_valid;
   logic        gene_ready;
   logic        gene_last;
   logic        busy;
   logic        done;

   gene_pair_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .parent_idx0  (parent_idx0),
      .parent_idx1  (parent_idx1),
      .genome_len   (genome_len),
      .mem_rd_en0   (mem_rd_en0),
      .mem_addr0    (mem_addr0),
      .mem_rdata0   (mem_rdata0),
      .mem_rd_en1   (mem_rd_en1),
      .mem_addr1    (mem_addr1),
      .mem_rdata1   (mem_rdata1),
      .parent_gene0 (parent_gene0),
      .parent_gene1 (parent_gene1),
      .gene_valid   (gene_valid),
      .gene_ready   (gene_ready),
      .gene_last    (gene_last),
      .busy         (busy),
      .done         (done)
   );

   typedef struct {
      logic [7:0]  idx0;
      logic [7:0]  idx1;
      logic [7:0]  len;
      logic [3:0]  ready_pat;
      logic [11:0] base0;
      logic [11:0] base1;
      int          dup_at;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [23:0] exp_addrs[$];
   logic [64:0] exp_pairs[$];
   int   outstanding;
   int   xfer_cnt, rd_cnt, done_cnt;
   int   first_xfer_cyc, last_xfer_cyc, done_cyc, start_cyc;
   logic stall_prev;
   logic [64:0] held;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] memf(input logic [11:0] a);
      return {20'hC3A5E, a};
   endfunction

   // Synchronous read ports: data one cycle after the strobe, garbage otherwise.
   always @(posedge clk) begin
      mem_rdata0 <= mem_rd_en0 ? memf(mem_addr0) : 32'hDEADDEAD;
      mem_rdata1 <= mem_rd_en1 ? memf(mem_addr1) : 32'hBEEFBEEF;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_exp(input logic [11:0] b0, input logic [11:0] b1, input logic [7:0] len);
      logic [11:0] a0, a1;
      for (int w = 0; w < int'(len); w++) begin
         a0 = b0 + 12'(w);
         a1 = b1 + 12'(w);
         exp_addrs.push_back({a0, a1});
         exp_pairs.push_back({memf(a0), memf(a1), (w == int'(len) - 1)});
      end
   endtask

   always @(negedge clk) begin
      logic xfer;
      logic [64:0] p;
      logic [23:0] a;
      if (!rst) begin
         exp_addrs.delete();
         exp_pairs.delete();
         outstanding = 0;
         stall_prev  = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", gene_valid, 1'b1);
            check("hold_data", {parent_gene0, parent_gene1, gene_last}, held);
         end
         stall_prev = gene_valid && !gene_ready;
         held       = {parent_gene0, parent_gene1, gene_last};
         xfer       = gene_valid && gene_ready;
         if (xfer) begin
            if (exp_pairs.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pair_extra actual=%0h required=none (cycle %0d)", held, cyc);
            end else begin
               p = exp_pairs.pop_front();
               check("pair", held, p);
            end
            if (xfer_cnt == 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            xfer_cnt++;
         end
         if (mem_rd_en0 || mem_rd_en1) begin
            check("rd_en_match", mem_rd_en1, mem_rd_en0);
            check("outstanding_le2", (outstanding - int'(xfer) + 1) <= 2, 1'b1);
            if (exp_addrs.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL addr_extra actual=%0d/%0d required=none (cycle %0d)", mem_addr0, mem_addr1, cyc);
            end else begin
               a = exp_addrs.pop_front();
               check("addr", {mem_addr0, mem_addr1}, a);
            end
            rd_cnt++;
         end
         outstanding = outstanding + int'(mem_rd_en0) - int'(xfer);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_strobes"}, {mem_rd_en0, mem_rd_en1, mem_addr0, mem_addr1}, '0);
      check({tag, "_genes"}, {parent_gene0, parent_gene1}, '0);
      check({tag, "_flags"}, {gene_valid, gene_last, busy, done}, '0);
   endtask

   task automatic run_cmd(input vec_t v);
      int n;
      xfer_cnt = 0;
      rd_cnt = 0;
      done_cnt = 0;
      first_xfer_cyc = -1;
      last_xfer_cyc = -1;
      done_cyc = -1;
      start = 1'b1;
      parent_idx0 = v.idx0;
      parent_idx1 = v.idx1;
      genome_len = v.len;
      gene_ready = v.ready_pat[0];
      start_cyc = cyc;
      push_exp(v.base0, v.base1, v.len);
      n = 1;
      @(posedge clk); #1;
      start = 1'b0;
      while (done_cnt == 0 && n < 500) begin
         gene_ready = v.ready_pat[n % 4];
         start = (n == v.dup_at);
         if (start) begin
            parent_idx0 = 8'd9;
            parent_idx1 = 8'd13;
            genome_len  = 8'd7;
         end
         n++;
         @(posedge clk); #1;
         start = 1'b0;
      end
      gene_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("done_count", done_cnt, 1);
      check("busy_after", busy, 1'b0);
      check("rd_count", rd_cnt, int'(v.len));
      check("xfer_count", xfer_cnt, int'(v.len));
      check("pairs_left", exp_pairs.size(), 0);
      if (v.len == 8'd0) begin
         check("done_cyc_len0", done_cyc, start_cyc + 2);
      end else begin
         check("done_after_last", done_cyc, last_xfer_cyc + 1);
         if (v.ready_pat == 4'b1111)
            check("throughput", last_xfer_cyc - first_xfer_cyc, int'(v.len) - 1);
      end
      $display("cmd idx0=%0d idx1=%0d len=%0d ready=%b: reads=%0d pairs=%0d done@%0d checks=%0d errors=%0d",
               v.idx0, v.idx1, v.len, v.ready_pat, rd_cnt, xfer_cnt, done_cyc, checks, errors);
   endtask

   vec_t vecs[7];
   vec_t after_rst;

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      start = 1'b0;
      parent_idx0 = '0;
      parent_idx1 = '0;
      genome_len = '0;
      gene_ready = 1'b0;

      // idx, idx, len, ready pattern (bit k drives cycle k mod 4), expected bases mod 4096, dup start
      vecs[0] = '{8'd2,   8'd5,   8'd4,  4'b1111, 12'd8,   12'd20,   -1};
      vecs[1] = '{8'd3,   8'd7,   8'd6,  4'b1001, 12'd18,  12'd42,   -1};
      vecs[2] = '{8'd9,   8'd11,  8'd0,  4'b1111, 12'd0,   12'd0,    -1};
      vecs[3] = '{8'd4,   8'd6,   8'd5,  4'b1111, 12'd20,  12'd30,    3};
      vecs[4] = '{8'd255, 8'd255, 8'd32, 4'b1111, 12'd4064, 12'd4064, -1};
      vecs[5] = '{8'd100, 8'd40,  8'd50, 4'b1011, 12'd904, 12'd2000, -1};
      vecs[6] = '{8'd17,  8'd17,  8'd3,  4'b0110, 12'd51,  12'd51,   -1};
      after_rst = '{8'd3, 8'd3, 8'd4, 4'b1111, 12'd12, 12'd12, -1};

      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b1;
      gene_ready = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         run_cmd(vecs[i]);
      end

      // Reset in the middle of a len=8 command after two pairs have left.
      xfer_cnt = 0;
      done_cnt = 0;
      start = 1'b1;
      parent_idx0 = 8'd1;
      parent_idx1 = 8'd2;
      genome_len = 8'd8;
      push_exp(12'd8, 12'd16, 8'd8);
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < 50 && xfer_cnt < 2; n++) begin
         @(posedge clk); #1;
      end
      check("rst_mid_reached", xfer_cnt, 2);
      rst = 1'b0;
      @(posedge clk); #1;
      check_idle_outputs("rst_mid");
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst_mid_no_done", done_cnt, 0);
      check("rst_mid_idle", {busy, gene_valid, mem_rd_en0}, 3'b000);
      run_cmd(after_rst);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gene_pair_fetch.md
Name: gene_pair_fetch

Overview:
- Producer side of the PE parent-gene interface.
- Reads the genomes of two selected parents, word by word, from the population buffer's two read ports.
- Streams aligned (parent_gene0, parent_gene1) pairs to the PE array with a valid/ready handshake.
- One start command fetches one full parent pair; genome length is per-command.

Parameters:
- GENE_W, 32, width of one gene word.
- ADDR_W, 12, population buffer word address width.
- IDX_W, 8, parent index width.
- LEN_W, 8, genome length (words) width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle command pulse; accepted only in IDLE.
- parent_idx0  in  IDX_W  index of parent 0; sampled on accepted start.
- parent_idx1  in  IDX_W  index of parent 1; sampled on accepted start.
- genome_len  in  LEN_W  words per genome; sampled on accepted start.
- mem_rd_en0  out  1  read strobe, port 0.
- mem_addr0  out  ADDR_W  read address, port 0.
- mem_rdata0  in  GENE_W  read data, port 0; valid exactly 1 cycle after mem_rd_en0.
- mem_rd_en1  out  1  read strobe, port 1.
- mem_addr1  out  ADDR_W  read address, port 1.
- mem_rdata1  in  GENE_W  read data, port 1; valid exactly 1 cycle after mem_rd_en1.
- parent_gene0  out  GENE_W  gene word from parent 0.
- parent_gene1  out  GENE_W  gene word from parent 1, same word offset as parent_gene0.
- gene_valid  out  1  pair valid.
- gene_ready  in  1  PE accepts pair.
- gene_last  out  1  marks final pair of the genome; qualified by gene_valid.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; all outputs 0, including gene data, strobes and addresses; skid buffer emptied; in-flight read discarded.
- Reset mid-command aborts immediately; no done pulse is generated.

FSM: IDLE -> SETUP -> FETCH -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 latches idx0, idx1 and len, then goes to SETUP; busy=1 from the next cycle.
- SETUP (1 cycle):
  - base0 = idx0*len and base1 = idx1*len, truncated to ADDR_W.
  - word counter cleared.
  - len==0: go to DONE directly; no reads and no valid pairs.
- FETCH:
  - Issue both reads in the same cycle (mem_rd_en0 = mem_rd_en1 = 1) at base+word, only if (buffer occupancy + in-flight) < 2.
  - Word counter increments per issued read.
  - After the read for word len-1 is issued, go to DRAIN.
- DRAIN: wait until the buffer is empty and no read is in flight, then go to DONE.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.

Data path and handshake:
- A read issued in cycle t returns data in cycle t+1, which is written into a 2-entry pair buffer (skid).
- The buffer head drives parent_gene0/1, gene_valid and gene_last; outputs come directly from buffer registers.
- A transfer occurs when gene_valid && gene_ready.
- While gene_valid=1 and gene_ready=0, data and gene_last are held stable.
- Simultaneous buffer write and pop in one cycle is legal; occupancy is unchanged.
- Word ordering is strictly increasing, 0 .. len-1; gene_last=1 only for word len-1.
- No pair is ever dropped or duplicated under arbitrary gene_ready patterns.

Throughput and latency:
- Steady-state throughput is 1 pair/cycle when gene_ready is held high.
- First gene_valid appears 3 cycles after start (SETUP, read, data capture).
- done asserts the cycle after the last transfer, or the cycle after SETUP when len==0.

Other rules:
- start while busy is ignored, with no side effects.
- Address arithmetic wraps modulo 2^ADDR_W; no overflow flag.
- idx0==idx1 is legal; both ports read identical addresses.

Decomposition:
- Shared package ga_pkg:
  - GENE_W default.
  - Fetch FSM state enum (IDLE, SETUP, FETCH, DRAIN, DONE).
  - Handshake helper constants shared with the child-gene collector.
- One sub-module: gene_pair_skid, a 2-entry FIFO of {gene0, gene1, last} with push/pop/occupancy.
- Address and FSM logic stay in gene_pair_fetch.

Test Plan:
- Basic stream: idx0=2, idx1=5, len=4, gene_ready=1 -> mem_addr0 = 8,9,10,11 and mem_addr1 = 20,21,22,23; four consecutive pairs; gene_last on the 4th; done 1 cycle later.
- Backpressure: len=6, gene_ready toggled 1,0,0,1,... -> all 6 pairs in order and data held stable while stalled; never more than 2 reads outstanding plus buffered.
- Zero length: len=0 -> no mem_rd_en, no gene_valid; done pulses 2 cycles after start.
- Start while busy: second start with different indices mid-stream -> ignored; only the first command's addresses appear; exactly one done.
- Reset mid-operation: rst=0 at word 2 of len=8 -> next cycle all outputs 0, no done; a new start then fetches from word 0 correctly.
- Wrap and same parent: idx0=idx1=255, len=32 with ADDR_W=12 -> both address streams wrap modulo 4096 identically (8160 mod 4096 = 4064 onward); pairs carry equal data.
